// File: rtl/nibble_add_sched_pkg.sv
// Shared constants, state encoding and the overflow helper for nibble_add_sched.
package nibble_add_sched_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Signed overflow of the top nibble: carry into its MSB differs from carry out.
  function automatic logic ovf_of(input logic a_msb, input logic b_msb,
                                  input logic s_msb, input logic co);
    return (a_msb ^ b_msb ^ s_msb) ^ co;
  endfunction

endpackage

// File: rtl/mux_adder_4bits.sv
// 4-bit carry-select adder slice: both carry cases are precomputed, carry-in picks one.
module mux_adder_4bits
  import nibble_add_sched_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] sum,
  output logic             co
);

  logic [NIB_W:0] sum0_s;
  logic [NIB_W:0] sum1_s;

  assign sum0_s = {1'b0, a} + {1'b0, b};
  assign sum1_s = {1'b0, a} + {1'b0, b} + 5'd1;

  // Carry-in selects between the two precomputed results.
  always_comb begin
    if (ci) begin
      sum = sum1_s[NIB_W-1:0];
      co  = sum1_s[NIB_W];
    end else begin
      sum = sum0_s[NIB_W-1:0];
      co  = sum0_s[NIB_W];
    end
  end

endmodule

// File: rtl/nibble_add_sched.sv
// Round-robin scheduler sharing one 4-bit adder slice; sums serially, LS nibble first.
// Optional signed-overflow output enabled by defining NIBBLE_ADD_SCHED_OVF_EN.
module nibble_add_sched
  import nibble_add_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_ci,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_ci,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_co,
  output logic             rsp_id
`ifdef NIBBLE_ADD_SCHED_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int CNT_W = $clog2(NIB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  state_e             state_r;
  logic               rr_last_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               id_r;
  logic               rsp_valid_r;
  logic               co_r;
  logic               ovf_r;

  logic               grant_s;
  logic               grant_vld_s;
  logic               accept_s;
  logic [WIDTH-1:0]   op_a_s;
  logic [WIDTH-1:0]   op_b_s;
  logic               op_ci_s;
  logic [CNT_W+1:0]   nib_lo_s;
  logic [NIB_W-1:0]   slice_a_s;
  logic [NIB_W-1:0]   slice_b_s;
  logic [NIB_W-1:0]   nib_sum_s;
  logic               nib_co_s;

  // Round-robin arbitration: on contention the requester not granted last wins.
  always_comb begin
    grant_s     = REQ0;
    grant_vld_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s     = ~rr_last_r;
      grant_vld_s = 1'b1;
    end else if (req0_valid) begin
      grant_s     = REQ0;
      grant_vld_s = 1'b1;
    end else if (req1_valid) begin
      grant_s     = REQ1;
      grant_vld_s = 1'b1;
    end else begin
      grant_s     = REQ0;
      grant_vld_s = 1'b0;
    end
  end

  assign accept_s = grant_vld_s && (state_r == IDLE);

  // Ready is only offered in IDLE, and is held low while reset is applied.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && accept_s) begin
      req0_ready = (grant_s == REQ0);
      req1_ready = (grant_s == REQ1);
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // Operand mux feeding the capture registers.
  always_comb begin
    op_a_s  = req0_a;
    op_b_s  = req0_b;
    op_ci_s = req0_ci;
    if (grant_s == REQ1) begin
      op_a_s  = req1_a;
      op_b_s  = req1_b;
      op_ci_s = req1_ci;
    end else begin
      op_a_s  = req0_a;
      op_b_s  = req0_b;
      op_ci_s = req0_ci;
    end
  end

  assign nib_lo_s  = {cnt_r, 2'b00};
  assign slice_a_s = a_r[nib_lo_s +: NIB_W];
  assign slice_b_s = b_r[nib_lo_s +: NIB_W];

  mux_adder_4bits u_slice (
    .a   (slice_a_s),
    .b   (slice_b_s),
    .ci  (carry_r),
    .sum (nib_sum_s),
    .co  (nib_co_s)
  );

  // Sequencer: capture on handshake, one nibble per RUN cycle, hold result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_last_r   <= REQ1;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      id_r        <= REQ0;
      rsp_valid_r <= 1'b0;
      co_r        <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r       <= op_a_s;
            b_r       <= op_b_s;
            carry_r   <= op_ci_s;
            cnt_r     <= '0;
            id_r      <= grant_s;
            rr_last_r <= grant_s;
            state_r   <= RUN;
          end else begin
            state_r   <= IDLE;
          end
        end
        RUN: begin
          sum_r[nib_lo_s +: NIB_W] <= nib_sum_s;
          carry_r <= nib_co_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            co_r        <= nib_co_s;
            ovf_r       <= ovf_of(slice_a_s[NIB_W-1], slice_b_s[NIB_W-1],
                                  nib_sum_s[NIB_W-1], nib_co_s);
            rsp_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r     <= RUN;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = sum_r;
  assign rsp_co    = co_r;
  assign rsp_id    = id_r;

`ifdef NIBBLE_ADD_SCHED_OVF_EN
  assign rsp_ovf = ovf_r;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_r;
`endif

endmodule

// File: tb/tb_nibble_add_sched.sv
// Randomised self-checking bench for nibble_add_sched against an arithmetic reference model.
module tb_nibble_add_sched;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req0_ci;
  logic             req1_valid, req1_ready, req1_ci;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_co, rsp_id;
  logic [WIDTH-1:0] rsp_sum;
`ifdef NIBBLE_ADD_SCHED_OVF_EN
  logic             rsp_ovf;
`endif

  nibble_add_sched #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ci    (req0_ci),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ci    (req1_ci),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_co     (rsp_co),
    .rsp_id     (rsp_id)
`ifdef NIBBLE_ADD_SCHED_OVF_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Requester-side model state
  logic [WIDTH-1:0] op_a [2];
  logic [WIDTH-1:0] op_b [2];
  logic             op_ci [2];
  logic             op_vld [2];
  logic             rr_last_m;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    case ($urandom_range(0, 5))
      0:       w = 32'h0000_0000;
      1:       w = 32'hFFFF_FFFF;
      2:       w = 32'h7FFF_FFFF;
      3:       w = 32'h8000_0000;
      default: w = $urandom;
    endcase
    return w;
  endfunction

  task automatic drive_reqs();
    req0_valid = op_vld[0];
    req0_a     = op_a[0];
    req0_b     = op_b[0];
    req0_ci    = op_ci[0];
    req1_valid = op_vld[1];
    req1_a     = op_a[1];
    req1_b     = op_b[1];
    req1_ci    = op_ci[1];
  endtask

  // keep: 0 = granted requester withdraws, 1 = it re-requests the same op, 2 = random
  task automatic run_op(input int stall, input int keep);
    int               exp_id, wait_n, lat;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] ea, eb;
    logic             eci, busy_ready, hold_ok, exp_ovf;

    if (op_vld[0] && op_vld[1]) exp_id = rr_last_m ? 0 : 1;
    else if (op_vld[1])         exp_id = 1;
    else                        exp_id = 0;

    drive_reqs();
    #1;
    wait_n = 0;
    while (!(req0_ready || req1_ready) && wait_n < 20) begin
      @(negedge clk);
      #1;
      wait_n++;
    end
    check_val("grant_wait", wait_n, 0);
    check_val("grant_id", {req1_ready, req0_ready}, (exp_id == 1) ? 2'b10 : 2'b01);

    ea      = op_a[exp_id];
    eb      = op_b[exp_id];
    eci     = op_ci[exp_id];
    full    = {1'b0, ea} + {1'b0, eb} + {{WIDTH{1'b0}}, eci};
    exp_ovf = (ea[WIDTH-1] == eb[WIDTH-1]) && (full[WIDTH-1] != ea[WIDTH-1]);
    rr_last_m = exp_id[0];

    @(negedge clk);
    if (keep == 0) begin
      op_vld[exp_id] = 1'b0;
    end else if (keep == 2) begin
      case ($urandom_range(0, 2))
        0: op_vld[exp_id] = 1'b0;
        1: begin
          op_a[exp_id]  = rand_word();
          op_b[exp_id]  = rand_word();
          op_ci[exp_id] = 1'($urandom_range(0, 1));
        end
        default: op_vld[exp_id] = 1'b1;
      endcase
      if (!op_vld[0] && !op_vld[1]) op_vld[exp_id] = 1'b1;
    end
    drive_reqs();
    #1;

    lat = 1;
    busy_ready = 1'b0;
    while (!rsp_valid && lat < 20) begin
      busy_ready = busy_ready | req0_ready | req1_ready;
      @(negedge clk);
      #1;
      lat++;
    end
    busy_ready = busy_ready | req0_ready | req1_ready;
    check_val("latency", lat, NIB + 1);
    check_val("ready_busy", busy_ready, 1'b0);
    check_val("sum", rsp_sum, full[WIDTH-1:0]);
    check_val("co", rsp_co, full[WIDTH]);
    check_val("id", rsp_id, exp_id[0]);
`ifdef NIBBLE_ADD_SCHED_OVF_EN
    check_val("ovf", rsp_ovf, exp_ovf);
`else
    if (exp_ovf === 1'bx) check_val("ovf_model", exp_ovf, 1'b0);
`endif

    hold_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      hold_ok = hold_ok && (rsp_valid === 1'b1) && (rsp_sum === full[WIDTH-1:0]) &&
                (rsp_co === full[WIDTH]) && (rsp_id === exp_id[0]) &&
                !req0_ready && !req1_ready;
    end
    if (stall > 0) check_val("done_hold", hold_ok, 1'b1);

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check_val("done_exit", rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 2; r++) begin
      op_a[r] = '0; op_b[r] = '0; op_ci[r] = 1'b0; op_vld[r] = 1'b0;
    end
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    op_vld[0] = 1'b1;
    drive_reqs();
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_valid", rsp_valid, 1'b0);
    check_val("rst_sum", rsp_sum, 32'h0);
    check_val("rst_co", rsp_co, 1'b0);
    check_val("rst_id", rsp_id, 1'b0);
    check_val("rst_ready", {req1_ready, req0_ready}, 2'b00);
`ifdef NIBBLE_ADD_SCHED_OVF_EN
    check_val("rst_ovf", rsp_ovf, 1'b0);
`endif
    @(negedge clk);
    rst_n     = 1'b1;
    rr_last_m = 1'b1;

    // Both requesters held valid: grants alternate starting with requester 0
    op_a[0] = 32'd1; op_b[0] = 32'd2; op_ci[0] = 1'b0; op_vld[0] = 1'b1;
    op_a[1] = 32'd3; op_b[1] = 32'd4; op_ci[1] = 1'b0; op_vld[1] = 1'b1;
    for (int i = 0; i < 4; i++) run_op(0, 1);

    op_vld[1] = 1'b0;
    op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'h0000_0001; op_ci[0] = 1'b0; op_vld[0] = 1'b1;
    run_op(5, 0);
    op_a[0] = 32'h1234_5678; op_b[0] = 32'h0000_0000; op_ci[0] = 1'b1; op_vld[0] = 1'b1;
    run_op(0, 0);
    op_a[0] = 32'h7FFF_FFFF; op_b[0] = 32'h0000_0001; op_ci[0] = 1'b0; op_vld[0] = 1'b1;
    run_op(1, 0);
    op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'hFFFF_FFFF; op_ci[0] = 1'b1; op_vld[0] = 1'b1;
    run_op(2, 0);

    // Reset in the middle of a RUN owned by requester 1
    op_a[0] = 32'h0000_0005; op_b[0] = 32'h0000_0006; op_ci[0] = 1'b0; op_vld[0] = 1'b1;
    op_a[1] = 32'h1111_1111; op_b[1] = 32'h1111_1111; op_ci[1] = 1'b0; op_vld[1] = 1'b1;
    drive_reqs();
    #1;
    check_val("pre_rst_grant", {req1_ready, req0_ready}, 2'b10);
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", rsp_valid, 1'b0);
    check_val("mid_rst_sum", rsp_sum, 32'h0);
    check_val("mid_rst_ready", {req1_ready, req0_ready}, 2'b00);
    @(negedge clk);
    rst_n     = 1'b1;
    rr_last_m = 1'b1;
    run_op(0, 0);

    for (int i = 0; i < 40; i++) begin
      if (!op_vld[0] && !op_vld[1]) begin
        op_vld[0] = 1'b1;
        op_a[0]   = rand_word();
        op_b[0]   = rand_word();
        op_ci[0]  = 1'($urandom_range(0, 1));
      end
      run_op($urandom_range(0, 3), 2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
